// File: rtl/grid_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : grid_memory_ctrl
// Description : W x H cell memory for the snake game. It has a game write
//               port, a registered game lookup port and a registered display
//               read port. A sweep FSM clears the grid and then seeds the
//               starting snake and food after reset or an init pulse.
//               Optional build macro GRID_SNAKE_COUNT_EN adds a live count of
//               snake cells (snake_count).
// Revision    : 1.0 - initial release
// ============================================================================
module grid_memory_ctrl #(
  parameter int GRID_W     = 15,
  parameter int GRID_H     = 15,
  parameter int CELL_BITS  = 2,
  parameter int COORD_BITS = 5,
  parameter int SNAKE_LEN  = 3,
  parameter int FOOD_X     = 10,
  parameter int FOOD_Y     = 3
) (
  input  logic                    clk,
  input  logic                    rst,       // asynchronous, active low
  input  logic                    init,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [COORD_BITS-1:0]   wr_x,
  input  logic [COORD_BITS-1:0]   wr_y,
  input  logic [CELL_BITS-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [COORD_BITS-1:0]   rd_x,
  input  logic [COORD_BITS-1:0]   rd_y,
  output logic [CELL_BITS-1:0]    rd_data,
  output logic                    rd_valid,
  input  logic [COORD_BITS-1:0]   vga_x,
  input  logic [COORD_BITS-1:0]   vga_y,
  output logic [CELL_BITS-1:0]    vga_data
`ifdef GRID_SNAKE_COUNT_EN
  ,
  output logic [COORD_BITS*2-1:0] snake_count
`endif
);

  localparam int CELLS     = GRID_W * GRID_H;
  localparam int ADDR_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int SWEEP_MAX = (CELLS > SNAKE_LEN + 1) ? CELLS : SNAKE_LEN + 1;
  localparam int IDX_W     = (SWEEP_MAX > 1) ? $clog2(SWEEP_MAX) : 1;

  localparam logic [CELL_BITS-1:0] CODE_EMPTY = CELL_BITS'(0);
  localparam logic [CELL_BITS-1:0] CODE_FOOD  = CELL_BITS'(1);
  localparam logic [CELL_BITS-1:0] CODE_SNAKE = CELL_BITS'(2);
  localparam logic [CELL_BITS-1:0] CODE_WALL  = CELL_BITS'(3);

  localparam logic [IDX_W-1:0]  LAST_CLEAR = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0]  SNAKE_END  = IDX_W'(SNAKE_LEN);
  localparam logic [ADDR_W-1:0] FOOD_ADDR  = ADDR_W'(FOOD_Y * GRID_W + FOOD_X);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SEED  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  function automatic logic in_range(input logic [COORD_BITS-1:0] x,
                                    input logic [COORD_BITS-1:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_BITS-1:0] x,
                                                  input logic [COORD_BITS-1:0] y);
    return ADDR_W'(int'(y) * GRID_W + int'(x));
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CELL_BITS-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [CELL_BITS-1:0]   vga_data_q, vga_data_d;
  logic [CELL_BITS-1:0]   mem_q [CELLS];

  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [CELL_BITS-1:0]   mem_wdata;

  logic                   wr_ok, rd_ok, vga_ok;
  logic [ADDR_W-1:0]      wr_addr, rd_addr, vga_addr;

  assign wr_ok    = in_range(wr_x, wr_y);
  assign rd_ok    = in_range(rd_x, rd_y);
  assign vga_ok   = in_range(vga_x, vga_y);
  assign wr_addr  = cell_addr(wr_x, wr_y);
  assign rd_addr  = cell_addr(rd_x, rd_y);
  assign vga_addr = cell_addr(vga_x, vga_y);

  assign ready    = (state_q == ST_READY);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign vga_data = vga_data_q;

  // Sweep FSM next state and the single memory write port (sweep or game)
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = CODE_EMPTY;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ADDR_W'(idx_q);
        mem_wdata = CODE_EMPTY;
        if (idx_q == LAST_CLEAR) begin
          state_d = ST_SEED;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_SEED: begin
        mem_we = 1'b1;
        if (idx_q < SNAKE_END) begin
          // Snake body lies along row 0, so the address is just x
          mem_waddr = ADDR_W'(idx_q);
          mem_wdata = CODE_SNAKE;
          idx_d     = idx_q + IDX_W'(1);
        end else begin
          mem_waddr = FOOD_ADDR;
          mem_wdata = CODE_FOOD;
          state_d   = ST_READY;
          idx_d     = '0;
        end
      end
      ST_READY: begin
        if (wr_en && wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = wr_data;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
    if (init) begin
      state_d = ST_CLEAR;
      idx_d   = '0;
    end
  end

  // Registered read ports; reads see the array before this edge's write
  always_comb begin
    rd_valid_d = ready && rd_en;
    rd_data_d  = rd_data_q;
    if (ready && rd_en) begin
      rd_data_d = rd_ok ? mem_q[rd_addr] : CODE_WALL;
    end
    vga_data_d = (ready && vga_ok) ? mem_q[vga_addr] : CODE_EMPTY;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      vga_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      vga_data_q <= vga_data_d;
    end
  end

  // Cell array: no reset, contents are rebuilt by the sweep
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef GRID_SNAKE_COUNT_EN
  localparam int CNT_W = COORD_BITS * 2;

  logic [CNT_W-1:0]     snake_count_q, snake_count_d;
  logic [CELL_BITS-1:0] old_cell;

  assign old_cell    = mem_q[mem_waddr];
  assign snake_count = snake_count_q;

  // Track snake cells: seeded count, then +/- on game writes that change it
  always_comb begin
    snake_count_d = snake_count_q;
    if (state_q == ST_SEED && idx_q < SNAKE_END) begin
      snake_count_d = snake_count_q + CNT_W'(1);
    end else if (state_q == ST_READY && mem_we) begin
      if (old_cell != CODE_SNAKE && mem_wdata == CODE_SNAKE) begin
        snake_count_d = snake_count_q + CNT_W'(1);
      end else if (old_cell == CODE_SNAKE && mem_wdata != CODE_SNAKE) begin
        snake_count_d = snake_count_q - CNT_W'(1);
      end
    end
    if (init) begin
      snake_count_d = '0;
    end
  end

  // Snake counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snake_count_q <= '0;
    end else begin
      snake_count_q <= snake_count_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_grid_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_grid_memory_ctrl
// Description : Scoreboard bench for grid_memory_ctrl. The stimulus process
//               queues expected lookup/display values; a monitor process
//               compares them when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_memory_ctrl;

  localparam int W  = 15;
  localparam int H  = 15;
  localparam int CB = 2;
  localparam int XB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic          ready;
  logic          wr_en = 1'b0;
  logic [XB-1:0] wr_x = '0, wr_y = '0;
  logic [CB-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [XB-1:0] rd_x = '0, rd_y = '0;
  logic [CB-1:0] rd_data;
  logic          rd_valid;
  logic [XB-1:0] vga_x = '0, vga_y = '0;
  logic [CB-1:0] vga_data;
`ifdef GRID_SNAKE_COUNT_EN
  logic [2*XB-1:0] snake_count;
`endif

  grid_memory_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_data (vga_data)
`ifdef GRID_SNAKE_COUNT_EN
    ,
    .snake_count (snake_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  val;
    string       tag;
  } exp_t;

  exp_t rd_q[$];
  exp_t vga_q[$];
  logic [1:0] model [H][W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: compares queued expectations against what the DUT presents
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_valid_unexpected", 32'd1, 32'd0);
        end else begin
          e = rd_q.pop_front();
          check({e.tag, "_cycle"}, cyc, e.cyc);
          check(e.tag, {30'd0, rd_data}, {30'd0, e.val});
        end
      end
      while (vga_q.size() > 0 && vga_q[0].cyc <= cyc) begin
        e = vga_q.pop_front();
        if (e.cyc < cyc) check({e.tag, "_missed"}, cyc, e.cyc);
        else             check(e.tag, {30'd0, vga_data}, {30'd0, e.val});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    init  = 1'b0;
  endtask

  task automatic exp_vga(input int x, input int y, input logic [1:0] v, input string tag);
    vga_x = XB'(x);
    vga_y = XB'(y);
    vga_q.push_back(exp_t'{cyc + 1, v, tag});
  endtask

  task automatic exp_rd(input int x, input int y, input logic [1:0] v, input string tag);
    rd_en = 1'b1;
    rd_x  = XB'(x);
    rd_y  = XB'(y);
    rd_q.push_back(exp_t'{cyc + 1, v, tag});
  endtask

  task automatic do_wr(input int x, input int y, input logic [1:0] d);
    wr_en   = 1'b1;
    wr_x    = XB'(x);
    wr_y    = XB'(y);
    wr_data = d;
    if (x < W && y < H) model[y][x] = d;
  endtask

  task automatic seed_model();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y][x] = 2'd0;
    for (int i = 0; i < 3; i++) model[0][i] = 2'd2;
    model[3][10] = 2'd1;
  endtask

  task automatic vga_sweep(input string tag);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        exp_vga(x, y, model[y][x], $sformatf("%s_vga(%0d,%0d)", tag, x, y));
        step();
      end
    end
    step();
    step();
  endtask

  // Count edges until ready while hammering the ports that must be ignored
  task automatic wait_ready(input string tag);
    int n;
    n       = 0;
    wr_en   = 1'b1;
    wr_x    = XB'(14);
    wr_y    = XB'(14);
    wr_data = 2'd2;
    rd_en   = 1'b1;
    rd_x    = XB'(0);
    rd_y    = XB'(0);
    vga_x   = XB'(0);
    vga_y   = XB'(0);
    while (!ready && n < 1000) begin
      if (n == 226) vga_q.push_back(exp_t'{cyc + 1, 2'd0, {tag, "_vga_not_ready"}});
      step();
      n++;
    end
    set_idle();
    check({tag, "_ready_latency"}, n, 229);
  endtask

  initial begin
    set_idle();
    // Reset state
    step();
    step();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_rd_data", {30'd0, rd_data}, 32'd0);
    check("reset_vga_data", {30'd0, vga_data}, 32'd0);
`ifdef GRID_SNAKE_COUNT_EN
    check("reset_snake_count", {22'd0, snake_count}, 32'd0);
`endif
    rst = 1'b1;
    wait_ready("boot");
    seed_model();
    vga_sweep("seed");
`ifdef GRID_SNAKE_COUNT_EN
    check("count_after_seed", {22'd0, snake_count}, 32'd3);
`endif

    // Write then look up next cycle
    do_wr(7, 7, 2'd2);
    step();
    set_idle();
    exp_rd(7, 7, 2'd2, "rd77");
    exp_vga(7, 7, 2'd2, "vga77");
    step();
    set_idle();

    // Same-cycle read and write: old value first, new value after
    exp_rd(4, 4, 2'd0, "rd44_old");
    exp_vga(4, 4, 2'd0, "vga44_old");
    do_wr(4, 4, 2'd1);
    step();
    set_idle();
    exp_rd(4, 4, 2'd1, "rd44_new");
    exp_vga(4, 4, 2'd1, "vga44_new");
    step();
    set_idle();
    step();
    check("rd_hold", {30'd0, rd_data}, 32'd1);
    check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

    // Out-of-range accesses
    exp_rd(15, 2, 2'd3, "rd_oob_x");
    step();
    set_idle();
    exp_rd(3, 15, 2'd3, "rd_oob_y");
    do_wr(2, 15, 2'd2);
    exp_vga(20, 20, 2'd0, "vga_oob");
    step();
    set_idle();
    do_wr(15, 0, 2'd2);
    exp_vga(15, 0, 2'd0, "vga_oob_x");
    step();
    set_idle();
    step();
    vga_sweep("post");

    // Re-initialise mid-operation
    init = 1'b1;
    step();
    init = 1'b0;
    check("ready_after_init", {31'd0, ready}, 32'd0);
    wait_ready("reinit");
    seed_model();
    vga_sweep("reseed");

`ifdef GRID_SNAKE_COUNT_EN
    check("count_after_reseed", {22'd0, snake_count}, 32'd3);
    do_wr(5, 5, 2'd2);
    step();
    set_idle();
    check("count_add", {22'd0, snake_count}, 32'd4);
    do_wr(0, 0, 2'd0);
    step();
    set_idle();
    check("count_remove", {22'd0, snake_count}, 32'd3);
    do_wr(5, 5, 2'd2);
    step();
    set_idle();
    check("count_rewrite", {22'd0, snake_count}, 32'd3);
`endif

    step();
    step();
    step();
    check("rd_queue_drained", rd_q.size(), 32'd0);
    check("vga_queue_drained", vga_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/grid_memory_ctrl.md
Name: grid_memory_ctrl

Overview:
- Parametrised successor to the snake-game world memory: a W x H grid of CELL_BITS-wide cells.
- Game-logic side has a write port and a registered lookup port. Display side has a registered read port.
- A hardware sweep FSM clears the grid and then seeds the initial snake and food after reset or on request. No cell is left uninitialised.
- Sits between the game controller and the VGA pixel generator.

Parameters:
- GRID_W, 15, grid width in cells
- GRID_H, 15, grid height in cells
- CELL_BITS, 2, bits per cell; codes: 0 = empty, 1 = food, 2 = snake, 3 = reserved
- COORD_BITS, 5, width of every x/y coordinate port
- SNAKE_LEN, 3, initial snake cells, placed at (0,0)..(SNAKE_LEN-1,0)
- FOOD_X, 10, initial food x
- FOOD_Y, 3, initial food y

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- init  input  1  synchronous pulse; restarts the clear/seed sweep
- ready  output  1  high when the sweep is done and the ports are live
- wr_en  input  1  game write strobe
- wr_x, wr_y  input  COORD_BITS  write coordinate, 0-based
- wr_data  input  CELL_BITS  value to write
- rd_en  input  1  game lookup strobe, used for collision/food checks
- rd_x, rd_y  input  COORD_BITS  lookup coordinate
- rd_data  output  CELL_BITS  lookup result
- rd_valid  output  1  pulses one cycle after an accepted rd_en
- vga_x, vga_y  input  COORD_BITS  display coordinate, sampled every cycle
- vga_data  output  CELL_BITS  display cell value, 1-cycle latency

Behaviour:
- Address = y*GRID_W + x. A coordinate is in range iff x < GRID_W and y < GRID_H.
- Reset (rst low): FSM = CLEAR, sweep index = 0, ready = 0, rd_data = 0, rd_valid = 0, vga_data = 0. The async reset does not clear the array.
- FSM states:
  - CLEAR: writes 0 to one cell per cycle at the sweep index, from 0 to GRID_W*GRID_H-1 (GRID_W*GRID_H cycles), then moves to SEED.
  - SEED: writes snake code to cells (i,0) for i = 0..SNAKE_LEN-1, one per cycle, then writes food code at (FOOD_X,FOOD_Y). Takes SNAKE_LEN+1 cycles, then moves to READY.
  - READY: ready = 1. Ports are live.
- init high in any state: next state CLEAR, index 0, ready = 0 next cycle.
- ready rises exactly GRID_W*GRID_H + SNAKE_LEN + 1 cycles after rst deasserts (default 229).
- While not ready:
  - wr_en and rd_en are ignored.
  - rd_valid stays 0.
  - vga_data = 0.
- Write (ready and wr_en): cell is updated at the clock edge. An out-of-range write is dropped silently.
- Game lookup (ready and rd_en): rd_data is registered and rd_valid = 1 on the next cycle.
  - An out-of-range lookup returns 3 (wall), so the controller detects border collisions.
  - rd_data holds its value when rd_en is low; rd_valid drops to 0.
- VGA read: vga_data is registered from (vga_x,vga_y) every cycle while ready. An out-of-range read returns 0.
- Same-cycle read and write to the same address: both read ports return the OLD value (read-before-write). The new value is visible on the next access.
- Writes at FOOD_X/FOOD_Y or snake cells during READY have no special handling.
- Reset mid-sweep restarts from CLEAR. Reset mid-operation discards any pending rd_valid.

Optional Feature:
- Macro GRID_SNAKE_COUNT_EN adds output snake_count [COORD_BITS*2-1:0].
- snake_count is reset to 0 and cleared on entering CLEAR.
- It increments on each SEED snake write.
- In READY, an accepted in-range write:
  - increments it when the old cell != 2 and the new value == 2;
  - decrements it when the old cell == 2 and the new value != 2;
  - otherwise leaves it unchanged.
- Without the macro, the port and the counter logic are absent and behaviour is otherwise identical.

Test Plan:
- Deassert rst, hold idle -> ready rises at cycle 229; VGA sweep reads 2 at (0..2,0), 1 at (10,3), 0 everywhere else.
- In READY: write (7,7)=2, then rd_en (7,7) next cycle -> rd_data = 2 with rd_valid one cycle later; vga at (7,7) shows 2 after 1 cycle.
- In READY: same-cycle wr (4,4)=1 and rd_en (4,4) -> rd_data = 0; repeat rd -> 1.
- Out of range: rd_en (15,2) -> rd_data = 3; wr (2,15)=2 -> no cell changes; vga (20,20) -> 0.
- Pulse init mid-READY after writes -> ready = 0 next cycle; after 229 cycles the grid equals the seed pattern, previous writes gone; wr_en during the sweep ignored.
- With GRID_SNAKE_COUNT_EN: after seed snake_count = 3; write (5,5)=2 -> 4; write (0,0)=0 -> 3; write (5,5)=2 again -> stays 3.
